// File: rtl/banner_render_ctrl_pkg.sv
// Shared constants, FSM encoding and key helper for the banner render controller.
// Geometry: ten 12x12 glyphs side by side, packed into a 1440-bit row-major map.
package banner_pkg;

    localparam int GLYPH_W         = 12;
    localparam int GLYPH_H         = 12;
    localparam int NUM_CHARS       = 10;
    localparam int KEY_W           = 5;
    localparam int GLYPH_BITS      = 144;
    localparam int MAP_BITS        = 1440;
    localparam int ROW_BITS        = GLYPH_W * NUM_CHARS;
    localparam int BANNER_KEY_BITS = KEY_W * NUM_CHARS;

    localparam logic [KEY_W-1:0] KEY_SPACE = 5'b11111;
    localparam logic [KEY_W-1:0] KEY_UP    = 5'b01011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Char 0 sits in the most significant key slot.
    function automatic logic [KEY_W-1:0] key_at(input logic [BANNER_KEY_BITS-1:0] keys,
                                                input logic [3:0] c);
        return keys[KEY_W*(NUM_CHARS-1-int'(c)) +: KEY_W];
    endfunction

endpackage

// File: rtl/banner_render_ctrl_if.sv
// Bundle between banner sources / font ROM (master) and the render controller (slave).
interface banner_render_ctrl_if
    import banner_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int OWN_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ*BANNER_KEY_BITS-1:0] keys;
    logic [NUM_REQ-1:0]                 ack;
    logic [KEY_W-1:0]                   rom_key;
    logic [GLYPH_BITS-1:0]              rom_glyph;
    logic [MAP_BITS-1:0]                pixel_map;
    logic                               map_valid;
    logic [OWN_W-1:0]                   map_owner;
    logic                               busy;

    modport master (
        output req, keys, rom_glyph,
        input  ack, rom_key, pixel_map, map_valid, map_owner, busy
    );

    modport slave (
        input  req, keys, rom_glyph,
        output ack, rom_key, pixel_map, map_valid, map_owner, busy
    );

endinterface

// File: rtl/banner_render_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or after the pointer.
// Combinational; the caller owns and advances the pointer.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_pointer,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0]   w_cand [NUM_REQ];
    logic [NUM_REQ-1:0] w_hit;
    logic               w_found;

    // w_cand[gi] is the source gi positions after the pointer, wrapped modulo NUM_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] w_sum;
            assign w_sum       = {1'b0, i_pointer} + (IDX_W+1)'(gi);
            assign w_cand[gi]  = (w_sum >= (IDX_W+1)'(NUM_REQ)) ?
                                 IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(w_sum);
            assign w_hit[gi]   = i_req[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        o_any   = i_enable && (|i_req);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_hit[k]) begin
                w_found = 1'b1;
                o_idx   = w_cand[k];
            end
        end
        if (i_enable && w_found) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/banner_render_ctrl.sv
// Time-multiplexed banner renderer: one shared font ROM port, one glyph per cycle,
// round-robin service of NUM_REQ banner sources into a single 1440-bit pixel map.
module banner_render_ctrl
    import banner_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ROM_LATENCY = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    banner_render_ctrl_if.slave  io_bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t                      r_state;
    state_t                      w_state_next;
    logic [BANNER_KEY_BITS-1:0]  r_keys;
    logic [IDX_W-1:0]            r_owner;
    logic [IDX_W-1:0]            r_ptr;
    logic [3:0]                  r_idx;
    logic [MAP_BITS-1:0]         r_map;
    logic                        r_map_valid;

    logic [NUM_REQ-1:0]          w_grant;
    logic [IDX_W-1:0]            w_gidx;
    logic                        w_any;
    logic [IDX_W-1:0]            w_ptr_next;
    logic [BANNER_KEY_BITS-1:0]  w_sel_keys;
    logic                        w_issue;
    logic                        w_ret_valid;
    logic [3:0]                  w_ret_idx;
    logic [MAP_BITS-1:0]         w_map_next;
    logic [NUM_REQ-1:0]          w_ack;
    logic                        w_busy;
    logic [KEY_W-1:0]            w_rom_key;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req     (io_bus.req),
        .i_pointer (r_ptr),
        .i_enable  (r_state == ST_IDLE),
        .o_grant   (w_grant),
        .o_idx     (w_gidx),
        .o_any     (w_any)
    );

    assign w_ptr_next = (w_gidx == IDX_W'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;
    assign w_issue    = (r_state == ST_FETCH) && (r_idx < 4'd10);

    always_comb begin
        w_sel_keys = '0;
        for (int s = 0; s < NUM_REQ; s++) begin
            if (w_grant[s]) begin
                w_sel_keys = w_sel_keys | io_bus.keys[BANNER_KEY_BITS*s +: BANNER_KEY_BITS];
            end
        end
    end

    // The char index travels alongside each key so a returning glyph knows its slot.
    generate
        if (ROM_LATENCY == 0) begin : g_rom_comb
            assign w_ret_valid = w_issue;
            assign w_ret_idx   = r_idx;
        end else begin : g_rom_pipe
            logic       r_dl_valid [ROM_LATENCY];
            logic [3:0] r_dl_idx   [ROM_LATENCY];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < ROM_LATENCY; i++) begin
                        r_dl_valid[i] <= 1'b0;
                        r_dl_idx[i]   <= '0;
                    end
                end else begin
                    r_dl_valid[0] <= w_issue;
                    r_dl_idx[0]   <= r_idx;
                    for (int i = 1; i < ROM_LATENCY; i++) begin
                        r_dl_valid[i] <= r_dl_valid[i-1];
                        r_dl_idx[i]   <= r_dl_idx[i-1];
                    end
                end
            end

            assign w_ret_valid = r_dl_valid[ROM_LATENCY-1];
            assign w_ret_idx   = r_dl_idx[ROM_LATENCY-1];
        end
    endgenerate

    always_comb begin
        w_map_next = r_map;
        for (int c = 0; c < NUM_CHARS; c++) begin
            if ((r_state == ST_FETCH) && w_ret_valid && (w_ret_idx == 4'(c))) begin
                for (int r = 0; r < GLYPH_H; r++) begin
                    w_map_next[MAP_BITS-1-ROW_BITS*r-GLYPH_W*c -: GLYPH_W] =
                        io_bus.rom_glyph[GLYPH_BITS-1-GLYPH_W*r -: GLYPH_W];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ack        = '0;
        w_busy       = 1'b0;
        w_rom_key    = KEY_SPACE;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_busy = 1'b1;
                if (w_issue) begin
                    w_rom_key = key_at(r_keys, r_idx);
                end
                if (w_ret_valid && (w_ret_idx == 4'd9)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_ack[r_owner] = 1'b1;
                w_state_next   = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_keys      <= '0;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_map       <= '0;
            r_map_valid <= 1'b0;
        end else begin
            r_map <= w_map_next;
            if ((r_state == ST_IDLE) && w_any) begin
                r_keys      <= w_sel_keys;
                r_owner     <= w_gidx;
                r_ptr       <= w_ptr_next;
                r_idx       <= '0;
                r_map_valid <= 1'b0;
            end
            if (w_issue) begin
                r_idx <= r_idx + 4'd1;
            end
            if ((r_state == ST_FETCH) && (w_state_next == ST_DONE)) begin
                r_map_valid <= 1'b1;
            end
        end
    end

    assign io_bus.ack       = w_ack;
    assign io_bus.busy      = w_busy;
    assign io_bus.rom_key   = w_rom_key;
    assign io_bus.pixel_map = r_map;
    assign io_bus.map_valid = r_map_valid;
    assign io_bus.map_owner = r_owner;

endmodule
